// File: rtl/smart_cam_kv.sv
// smart_cam_kv: fully-associative key/value CAM with a pipelined lookup port,
// an insert/delete update port and a used-bit aging scrubber.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   init_enb_i/init_done_o  start the entry-clear sequence / CAM is live
//   aging_time_i            cycles per scrub tick, 0 disables aging
//   size_o                  number of valid entries
//   lookup_req_*_i          lookup request (1 per cycle, no backpressure)
//   lookup_resp_*_o         lookup response, 2 cycles after request
//   update_*_i              insert/delete request, held until update_ack_o
//   update_ack_o/status_o   1-cycle completion pulse, 0 ok / 1 full / 2 not found
//   hit_cnt_o, miss_cnt_o   lookup statistics
//
// Build option: define SMART_CAM_STATS_EN to enable the saturating
// hit/miss counters; otherwise both counters read as constant 0.
module smart_cam_kv #(
    parameter int KEY_W = 32,
    parameter int VAL_W = 48,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   init_enb_i,
    output logic                   init_done_o,
    input  logic [31:0]            aging_time_i,
    output logic [$clog2(DEPTH):0] size_o,
    input  logic                   lookup_req_valid_i,
    input  logic [KEY_W-1:0]       lookup_req_key_i,
    output logic                   lookup_resp_valid_o,
    output logic                   lookup_resp_hit_o,
    output logic [KEY_W-1:0]       lookup_resp_key_o,
    output logic [VAL_W-1:0]       lookup_resp_value_o,
    input  logic                   update_valid_i,
    input  logic                   update_op_i,
    input  logic [KEY_W-1:0]       update_key_i,
    input  logic                   update_static_i,
    input  logic [VAL_W-1:0]       update_value_i,
    output logic                   update_ack_o,
    output logic [1:0]             update_status_o,
    output logic [31:0]            hit_cnt_o,
    output logic [31:0]            miss_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_SEARCH = 2'd1, S_EXEC = 2'd2, S_ACK = 2'd3;

    logic [DEPTH-1:0] valid_q, static_q, used_q;
    logic [KEY_W-1:0] key_q [DEPTH];
    logic [VAL_W-1:0] val_q [DEPTH];

    logic          init_done_q, init_busy_q, init_run;
    logic [AW-1:0] init_ptr_q;

    logic             lk_vld_q, lk_hit, lk_set;
    logic [KEY_W-1:0] lk_key_q;
    logic [DEPTH-1:0] lk_match_d, lk_match_q;
    logic [AW-1:0]    lk_idx;
    logic             resp_valid_q, resp_hit_q;
    logic [KEY_W-1:0] resp_key_q;
    logic [VAL_W-1:0] resp_val_q;

    logic [1:0]       st_q;
    logic             op_q, ustat_q, ack_q;
    logic [1:0]       status_q;
    logic [KEY_W-1:0] ukey_q;
    logic [VAL_W-1:0] uval_q;
    logic [DEPTH-1:0] um_d, um_q;
    logic [AW-1:0]    free_idx_d, free_idx_q, up_idx, wr_idx;
    logic             free_ok_q, up_hit, wr_en;

    logic [31:0]   tick_q;
    logic [AW-1:0] sc_ptr_q;
    logic          tick_wrap, sc_skip, sc_clr_used, sc_kill;

    assign init_run = (init_enb_i | init_busy_q) & ~init_done_q;

    // Match vectors: lookups see the pre-write contents of this cycle.
    always_comb begin
        lk_match_d = '0;
        um_d       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lk_match_d[i] = init_done_q & valid_q[i] & (key_q[i] == lookup_req_key_i);
            um_d[i]       = valid_q[i] & (key_q[i] == ukey_q);
        end
    end

    // Lowest-index priority encoders (downward loop so the lowest wins).
    always_comb begin
        lk_idx     = '0;
        up_idx     = '0;
        free_idx_d = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (lk_match_q[i]) lk_idx = AW'(i);
            if (um_q[i]) up_idx = AW'(i);
            if (!valid_q[i]) free_idx_d = AW'(i);
        end
    end

    assign lk_hit = |lk_match_q;
    assign lk_set = lk_vld_q & lk_hit & valid_q[lk_idx];

    assign up_hit = |um_q;
    assign wr_idx = up_hit ? up_idx : free_idx_q;
    assign wr_en  = (st_q == S_EXEC) & (op_q ? up_hit : (up_hit | free_ok_q));

    // Scrubber yields to an update write or a lookup used-set on its entry.
    assign tick_wrap   = init_done_q & (aging_time_i != 32'd0) & (tick_q >= aging_time_i - 32'd1);
    assign sc_skip     = (wr_en & (wr_idx == sc_ptr_q)) | (lk_set & (lk_idx == sc_ptr_q));
    assign sc_clr_used = tick_wrap & ~sc_skip & used_q[sc_ptr_q];
    assign sc_kill     = tick_wrap & ~sc_skip & ~used_q[sc_ptr_q] & valid_q[sc_ptr_q] & ~static_q[sc_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            static_q     <= '0;
            used_q       <= '0;
            init_done_q  <= 1'b0;
            init_busy_q  <= 1'b0;
            init_ptr_q   <= '0;
            lk_vld_q     <= 1'b0;
            lk_key_q     <= '0;
            lk_match_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_key_q   <= '0;
            resp_val_q   <= '0;
            st_q         <= S_IDLE;
            op_q         <= 1'b0;
            ustat_q      <= 1'b0;
            ack_q        <= 1'b0;
            status_q     <= 2'd0;
            um_q         <= '0;
            free_idx_q   <= '0;
            free_ok_q    <= 1'b0;
            tick_q       <= '0;
            sc_ptr_q     <= '0;
        end else begin
            if (init_run) begin
                valid_q[init_ptr_q]  <= 1'b0;
                static_q[init_ptr_q] <= 1'b0;
                used_q[init_ptr_q]   <= 1'b0;
                key_q[init_ptr_q]    <= '0;
                val_q[init_ptr_q]    <= '0;
                init_ptr_q           <= init_ptr_q + AW'(1);
                init_busy_q          <= init_ptr_q != AW'(DEPTH - 1);
                init_done_q          <= init_ptr_q == AW'(DEPTH - 1);
            end
            lk_vld_q     <= lookup_req_valid_i;
            lk_key_q     <= lookup_req_key_i;
            lk_match_q   <= lk_match_d;
            resp_valid_q <= lk_vld_q;
            resp_hit_q   <= lk_vld_q & lk_hit;
            resp_key_q   <= lk_key_q;
            resp_val_q   <= (lk_vld_q & lk_hit) ? val_q[lk_idx] : '0;
            if (lk_set) used_q[lk_idx] <= 1'b1;
            if (sc_clr_used) used_q[sc_ptr_q] <= 1'b0;
            if (sc_kill) valid_q[sc_ptr_q] <= 1'b0;
            if (tick_wrap) sc_ptr_q <= sc_ptr_q + AW'(1);
            tick_q <= (!init_done_q || aging_time_i == 32'd0 || tick_wrap) ? 32'd0 : tick_q + 32'd1;
            ack_q <= 1'b0;
            case (st_q)
                S_IDLE: if (update_valid_i && init_done_q) begin
                    op_q    <= update_op_i;
                    ukey_q  <= update_key_i;
                    uval_q  <= update_value_i;
                    ustat_q <= update_static_i;
                    st_q    <= S_SEARCH;
                end
                S_SEARCH: begin
                    um_q       <= um_d;
                    free_idx_q <= free_idx_d;
                    free_ok_q  <= ~&valid_q;
                    st_q       <= S_EXEC;
                end
                S_EXEC: begin
                    if (wr_en && op_q) valid_q[wr_idx] <= 1'b0;
                    if (wr_en && !op_q) begin
                        valid_q[wr_idx]  <= 1'b1;
                        used_q[wr_idx]   <= 1'b1;
                        static_q[wr_idx] <= ustat_q;
                        key_q[wr_idx]    <= ukey_q;
                        val_q[wr_idx]    <= uval_q;
                    end
                    status_q <= op_q ? (up_hit ? 2'd0 : 2'd2) : ((up_hit | free_ok_q) ? 2'd0 : 2'd1);
                    ack_q    <= 1'b1;
                    st_q     <= S_ACK;
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

    // Size is derived from the valid bits, so it can never drift or wrap.
    always_comb begin
        size_o = '0;
        for (int i = 0; i < DEPTH; i++) size_o = size_o + {{AW{1'b0}}, valid_q[i]};
    end

`ifdef SMART_CAM_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (lk_vld_q && init_done_q) begin
            if (lk_hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (!lk_hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

    assign init_done_o         = init_done_q;
    assign lookup_resp_valid_o = resp_valid_q;
    assign lookup_resp_hit_o   = resp_hit_q;
    assign lookup_resp_key_o   = resp_key_q;
    assign lookup_resp_value_o = resp_val_q;
    assign update_ack_o        = ack_q;
    assign update_status_o     = status_q;
endmodule
